// File: rtl/tx_scheduler.sv
// tx_scheduler: transmit byte FIFO plus a two-state frame sequencer for
// tx_frontend. The line configuration is captured at each frame issue so
// that register writes during a frame cannot disturb the frame in flight.
module tx_scheduler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [7:0]       wdata_i,
    input  logic             flush_i,
    input  logic             ovf_clr_i,
    input  logic [15:0]      cr_acc_incr_i,
    input  logic             cr_ds_i,
    input  logic [1:0]       cr_p_i,
    input  logic             cr_s_i,
    output logic [15:0]      cr_acc_incr_o,
    output logic             cr_ds_o,
    output logic [1:0]       cr_p_o,
    output logic             cr_s_o,
    output logic             transmit_o,
    output logic [7:0]       dr_o,
    input  logic             done_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             txe_o,
    output logic             ovf_o,
    output logic             frame_done_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             busy_q, busy_d;
    logic             txe_q, txe_d;
    logic             ovf_q, ovf_d;
    logic             transmit_q, transmit_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       dr_q, dr_d;
    logic [15:0]      cr_acc_incr_q, cr_acc_incr_d;
    logic             cr_ds_q, cr_ds_d;
    logic [1:0]       cr_p_q, cr_p_d;
    logic             cr_s_q, cr_s_d;

    logic             issue;
    logic             push;
    logic             overflow;

    // Next-state computation; full/empty decisions use the pre-edge flags.
    always_comb begin
        issue    = (state_q == IDLE) && en_i && !empty_q && !flush_i;
        push     = wr_i && !full_q && !flush_i;
        overflow = wr_i && full_q && !flush_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(issue);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);

        // Set wins over clear when both happen in the same cycle.
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        state_d = state_q;
        case (state_q)
            IDLE: if (issue) state_d = BUSY;
            BUSY: if (done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d == BUSY);
        txe_d        = empty_d && !busy_d;
        transmit_d   = issue;
        frame_done_d = done_i;

        dr_d          = dr_q;
        cr_acc_incr_d = cr_acc_incr_q;
        cr_ds_d       = cr_ds_q;
        cr_p_d        = cr_p_q;
        cr_s_d        = cr_s_q;
        if (issue) begin
            dr_d          = mem_q[rd_ptr_q];
            cr_acc_incr_d = cr_acc_incr_i;
            cr_ds_d       = cr_ds_i;
            cr_p_d        = cr_p_i;
            cr_s_d        = cr_s_i;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Sequencer state, FIFO bookkeeping and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            busy_q        <= 1'b0;
            txe_q         <= 1'b1;
            ovf_q         <= 1'b0;
            transmit_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            dr_q          <= '0;
            cr_acc_incr_q <= '0;
            cr_ds_q       <= 1'b0;
            cr_p_q        <= '0;
            cr_s_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            busy_q        <= busy_d;
            txe_q         <= txe_d;
            ovf_q         <= ovf_d;
            transmit_q    <= transmit_d;
            frame_done_q  <= frame_done_d;
            dr_q          <= dr_d;
            cr_acc_incr_q <= cr_acc_incr_d;
            cr_ds_q       <= cr_ds_d;
            cr_p_q        <= cr_p_d;
            cr_s_q        <= cr_s_d;
        end
    end

    assign cr_acc_incr_o = cr_acc_incr_q;
    assign cr_ds_o       = cr_ds_q;
    assign cr_p_o        = cr_p_q;
    assign cr_s_o        = cr_s_q;
    assign transmit_o    = transmit_q;
    assign dr_o          = dr_q;
    assign full_o        = full_q;
    assign empty_o       = empty_q;
    assign count_o       = count_q;
    assign busy_o        = busy_q;
    assign txe_o         = txe_q;
    assign ovf_o         = ovf_q;
    assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: stimulus pushes expected frames,
// a monitor pops and compares on every transmit_o pulse.
module tb_tx_scheduler;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i, wr_i, flush_i, ovf_clr_i;
    logic [7:0]       wdata_i;
    logic [15:0]      cr_acc_incr_i;
    logic             cr_ds_i, cr_s_i;
    logic [1:0]       cr_p_i;
    logic [15:0]      cr_acc_incr_o;
    logic             cr_ds_o, cr_s_o;
    logic [1:0]       cr_p_o;
    logic             transmit_o;
    logic [7:0]       dr_o;
    logic             done_i;
    logic             full_o, empty_o, busy_o, txe_o, ovf_o, frame_done_o;
    logic [CNT_W-1:0] count_o;

    tx_scheduler #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en_i), .wr_i(wr_i), .wdata_i(wdata_i),
        .flush_i(flush_i), .ovf_clr_i(ovf_clr_i),
        .cr_acc_incr_i(cr_acc_incr_i), .cr_ds_i(cr_ds_i), .cr_p_i(cr_p_i), .cr_s_i(cr_s_i),
        .cr_acc_incr_o(cr_acc_incr_o), .cr_ds_o(cr_ds_o), .cr_p_o(cr_p_o), .cr_s_o(cr_s_o),
        .transmit_o(transmit_o), .dr_o(dr_o), .done_i(done_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .busy_o(busy_o),
        .txe_o(txe_o), .ovf_o(ovf_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] p;
        int         cyc;   // absolute cycle of the pulse, or -1 if not pinned
        bit         gap;   // pulse must land two cycles after the last done_i
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_done_cyc = -100;
    int   done_delay = 5;
    logic prev_tx = 1'b0;
    logic prev_done = 1'b0;
    logic prev_rst = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: frame pulses against the scoreboard, frame_done_o against done_i.
    always @(negedge clk) begin
        if (transmit_o) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_tx: got transmit_o=1 dr_o=0x%0h expected no frame (cycle %0d)", dr_o, cyc);
            end else begin
                got = sb.pop_front();
                check("tx_dr", dr_o, got.data);
                check("tx_cr_p", cr_p_o, got.p);
                check("tx_busy", busy_o, 1);
                if (got.cyc >= 0) check("tx_latency", cyc, got.cyc);
                if (got.gap) check("tx_after_done", cyc, last_done_cyc + 2);
            end
            check("tx_pulse_width", prev_tx, 0);
        end
        if (!rst && !prev_rst) check("frame_done", frame_done_o, prev_done);
        if (done_i) last_done_cyc = cyc;
        prev_done = done_i;
        prev_tx   = transmit_o;
        prev_rst  = rst;
    end

    // Frame-complete responder modelling tx_frontend.
    initial begin
        done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (transmit_o) begin
                repeat (done_delay) @(posedge clk);
                #1 done_i = 1'b1;
                @(posedge clk);
                #1 done_i = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_i = 1'b1;
        wdata_i = b;
        tick();
        wr_i = 1'b0;
    endtask

    task automatic expect_tx(input logic [7:0] d, input logic [1:0] p, input int c, input bit g);
        exp_t e;
        e.data = d;
        e.p = p;
        e.cyc = c;
        e.gap = g;
        sb.push_back(e);
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!transmit_o && n < 300);
        check({tag, "_tx_timeout"}, n < 300, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(busy_o == 1'b0 && txe_o == 1'b1 && sb.size() == 0) && n < 600) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, n < 600, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, count_o, 0);
        check({tag, "_empty"}, empty_o, 1);
        check({tag, "_full"}, full_o, 0);
        check({tag, "_txe"}, txe_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_transmit"}, transmit_o, 0);
        check({tag, "_dr"}, dr_o, 0);
        check({tag, "_cr_acc"}, cr_acc_incr_o, 0);
        check({tag, "_cr_ds"}, cr_ds_o, 0);
        check({tag, "_cr_p"}, cr_p_o, 0);
        check({tag, "_cr_s"}, cr_s_o, 0);
        check({tag, "_ovf"}, ovf_o, 0);
        check({tag, "_frame_done"}, frame_done_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en_i = 1'b0; wr_i = 1'b0; flush_i = 1'b0; ovf_clr_i = 1'b0;
        wdata_i = '0;
        cr_acc_incr_i = 16'h1234; cr_ds_i = 1'b1; cr_p_i = 2'b10; cr_s_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_vals("reset");

        // Single byte: pulse two cycles after the write cycle.
        en_i = 1'b1;
        done_delay = 5;
        expect_tx(8'hA5, 2'b10, cyc + 2, 1'b0);
        write_byte(8'hA5);
        check("t1_count_after_wr", count_o, 1);
        check("t1_empty_after_wr", empty_o, 0);
        tick();
        check("t1_busy", busy_o, 1);
        check("t1_cr_acc", cr_acc_incr_o, 16'h1234);
        check("t1_cr_ds", cr_ds_o, 1);
        check("t1_cr_s", cr_s_o, 1);
        wait_idle("t1");
        check("t1_busy_done", busy_o, 0);
        check("t1_txe_done", txe_o, 1);

        // Three queued bytes, done_i 50 cycles after each pulse.
        en_i = 1'b0;
        done_delay = 50;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        check("t2_count3", count_o, 3);
        en_i = 1'b1;
        expect_tx(8'h11, 2'b10, cyc + 1, 1'b0);
        expect_tx(8'h22, 2'b10, -1, 1'b1);
        expect_tx(8'h33, 2'b10, -1, 1'b1);
        tick();
        check("t2_count2", count_o, 2);
        wait_tx("t2a");
        check("t2_count1", count_o, 1);
        wait_tx("t2b");
        check("t2_count0", count_o, 0);
        wait_idle("t2");

        // Overflow with the transmitter disabled.
        en_i = 1'b0;
        done_delay = 3;
        for (int i = 0; i <= DEPTH; i++) write_byte(8'h40 + 8'(i));
        check("t3_full", full_o, 1);
        check("t3_count", count_o, DEPTH);
        check("t3_ovf", ovf_o, 1);
        ovf_clr_i = 1'b1;
        write_byte(8'hEE);
        ovf_clr_i = 1'b0;
        check("t3_ovf_set_wins", ovf_o, 1);
        check("t3_count_held", count_o, DEPTH);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("t3_ovf_cleared", ovf_o, 0);
        en_i = 1'b1;
        expect_tx(8'h40, 2'b10, cyc + 1, 1'b0);
        for (int i = 1; i < DEPTH; i++) expect_tx(8'h40 + 8'(i), 2'b10, -1, 1'b1);
        wait_idle("t3");

        // Line configuration captured only at issue.
        done_delay = 20;
        cr_p_i = 2'b01;
        expect_tx(8'h5A, 2'b01, cyc + 2, 1'b0);
        write_byte(8'h5A);
        tick();
        cr_p_i = 2'b00;
        expect_tx(8'h6B, 2'b00, -1, 1'b1);
        write_byte(8'h6B);
        repeat (3) tick();
        check("t4_cr_p_held", cr_p_o, 2'b01);
        wait_idle("t4");
        check("t4_cr_p_new", cr_p_o, 2'b00);

        // Flush with a frame in flight and a simultaneous write.
        en_i = 1'b0;
        done_delay = 30;
        for (int i = 0; i < 5; i++) write_byte(8'h71 + 8'(i));
        en_i = 1'b1;
        expect_tx(8'h71, 2'b00, cyc + 1, 1'b0);
        tick();
        check("t5_count4", count_o, 4);
        flush_i = 1'b1;
        write_byte(8'h99);
        flush_i = 1'b0;
        check("t5_count", count_o, 0);
        check("t5_empty", empty_o, 1);
        check("t5_busy", busy_o, 1);
        check("t5_ovf", ovf_o, 0);
        wait_idle("t5");
        repeat (20) tick();
        check("t5_busy_end", busy_o, 0);
        check("t5_txe_end", txe_o, 1);

        // Asynchronous reset mid-frame with bytes still queued.
        en_i = 1'b0;
        done_delay = 40;
        write_byte(8'h81);
        write_byte(8'h82);
        write_byte(8'h83);
        en_i = 1'b1;
        expect_tx(8'h81, 2'b00, cyc + 1, 1'b0);
        repeat (3) tick();
        check("t6_busy_before", busy_o, 1);
        #3 rst = 1'b1;
        #1 check_reset_vals("t6_async");
        tick();
        rst = 1'b0;
        repeat (60) tick();
        check("t6_count_after", count_o, 0);
        check("t6_busy_after", busy_o, 0);
        done_delay = 5;
        expect_tx(8'hC3, 2'b00, cyc + 2, 1'b0);
        write_byte(8'hC3);
        wait_idle("t6");

        repeat (5) tick();
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
